// File: rtl/sqrt_uns_pkg.sv
// sqrt_uns_pkg: shared types, constants and helpers for the sequential
// unsigned square-root unit (sqrt_uns_seq).
// Optional feature macro: SQRT_UNS_SEQ_EARLY_EXIT_EN (uses countZeroPairs).

package sqrt_uns_pkg;

   // Controller states: waiting for an operand, iterating, holding a result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sqrtState_t;

   // Default root width; the operand is twice as wide
   localparam int DefaultRootWidth = 8;

   // Iteration counter width for the default root width, $clog2(width+1)
   localparam int IterCntWidth = $clog2(DefaultRootWidth + 1);

   // Iteration counter width for an arbitrary root width
   function automatic int cntWidthFor(input int w);
      return $clog2(w + 1);
   endfunction

   // Number of leading all-zero bit pairs in a 2*w-bit operand (0..w).
   // The operand sits in the low 2*w bits of x; w must not exceed 64.
   function automatic int countZeroPairs(input logic [127:0] x, input int w);
      int   count;
      logic seenOne;
      count   = 0;
      seenOne = 1'b0;
      for (int i = w - 1; i >= 0; i--) begin
         if (!seenOne && (x[2*i +: 2] == 2'b00)) begin
            count++;
         end else begin
            seenOne = 1'b1;
         end
      end
      return count;
   endfunction

endpackage

// File: rtl/sqrt_uns_step.sv
// sqrt_uns_step: one restoring digit-by-digit square-root iteration.
// Brings down the next two operand bits, tries to subtract {root, 01} and
// keeps the difference when it does not borrow. Purely combinational.
// Optional feature macro of the enclosing unit: SQRT_UNS_SEQ_EARLY_EXIT_EN
// (no effect here).

module sqrt_uns_step
   import sqrt_uns_pkg::*;
#(
   parameter int width = DefaultRootWidth
) (
   input  logic [width+1:0] rem_i,
   input  logic [width-1:0] root_i,
   input  logic [1:0]       digit_i,
   output logic [width+1:0] rem_o,
   output logic             rootBit_o
);

   logic [width+1:0] remShift;
   logic [width+1:0] trial;
   logic [width+2:0] diff;

   // The partial remainder never exceeds 2*root, so the shifted value always
   // fits in width+2 bits and the top two bits of rem_i can be dropped.
   assign remShift = (width+2)'({rem_i, digit_i});
   assign trial    = {root_i, 2'b01};

   // Extra top bit of the difference is the borrow: set means trial > remShift
   assign diff      = {1'b0, remShift} - {1'b0, trial};
   assign rootBit_o = ~diff[width+2];
   assign rem_o     = diff[width+2] ? remShift : diff[width+1:0];

endmodule

// File: rtl/sqrt_uns_seq.sv
// sqrt_uns_seq: iterative unsigned square root, Q = floor(sqrt(X)),
// R = X - Q*Q, producing one root bit per clock with valid/ready handshakes
// on both sides. Latency is width cycles from accept to result valid.
// Optional feature macro: SQRT_UNS_SEQ_EARLY_EXIT_EN - skips leading all-zero
// bit pairs of the operand, so latency becomes max(1, width - zeroPairs).
// width must be at least 2.

module sqrt_uns_seq
   import sqrt_uns_pkg::*;
#(
   parameter int width = DefaultRootWidth
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [2*width-1:0] X,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic [width-1:0]   Q,
   output logic [width:0]     R,
   output logic               out_valid_o,
   input  logic               out_ready_i
);

   localparam int CntW = cntWidthFor(width);

   sqrtState_t         state_q;
   logic [2*width-1:0] op_q;
   logic [width+1:0]   rem_q;
   logic [width-1:0]   root_q;
   logic [CntW-1:0]    cnt_q;
   logic               inReady_q;
   logic               outValid_q;

   logic [width+1:0]   rem_d;
   logic [width-1:0]   root_d;
   logic               rootBit;
   logic [2*width-1:0] opLoad;
   logic [CntW-1:0]    cntLoad;

   sqrt_uns_step #(
      .width(width)
   ) u_step (
      .rem_i    (rem_q),
      .root_i   (root_q),
      .digit_i  (op_q[2*width-1 -: 2]),
      .rem_o    (rem_d),
      .rootBit_o(rootBit)
   );

   assign root_d = {root_q[width-2:0], rootBit};

`ifdef SQRT_UNS_SEQ_EARLY_EXIT_EN
   int zeroPairs;

   // Skip the operand's leading zero pairs: they would only shift zeros into
   // the root, so the operand is pre-aligned and the iteration count reduced.
   always_comb begin
      zeroPairs = countZeroPairs(128'(X), width);
      opLoad    = X << (2 * zeroPairs);
      if (zeroPairs >= width) begin
         cntLoad = CntW'(1);
      end else begin
         cntLoad = CntW'(width - zeroPairs);
      end
   end
`else
   // Always walk every bit pair of the operand
   always_comb begin
      opLoad  = X;
      cntLoad = CntW'(width);
   end
`endif

   // Controller, datapath registers and registered handshake flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         op_q       <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         cnt_q      <= '0;
         inReady_q  <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               inReady_q <= 1'b1;
               if (in_valid_i && inReady_q) begin
                  op_q      <= opLoad;
                  rem_q     <= '0;
                  root_q    <= '0;
                  cnt_q     <= cntLoad;
                  inReady_q <= 1'b0;
                  state_q   <= CALC;
               end
            end
            CALC: begin
               rem_q  <= rem_d;
               root_q <= root_d;
               op_q   <= op_q << 2;
               cnt_q  <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               inReady_q  <= 1'b0;
               outValid_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   // Root and remainder registers are untouched in DONE, so results hold
   // steady under backpressure.
   assign Q           = root_q;
   assign R           = (width+1)'(rem_q);
   assign in_ready_o  = inReady_q;
   assign out_valid_o = outValid_q;

endmodule

// File: tb/tb_sqrt_uns_seq.sv
// tb_sqrt_uns_seq: directed self-checking bench for sqrt_uns_seq (width 8).
// Build with +define+SQRT_UNS_SEQ_EARLY_EXIT_EN to expect early-exit latencies.

module tb_sqrt_uns_seq;

   localparam int Width = 8;
`ifdef SQRT_UNS_SEQ_EARLY_EXIT_EN
   localparam bit EarlyExit = 1'b1;
`else
   localparam bit EarlyExit = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] X;
   logic        inValid;
   logic        inReady;
   logic [7:0]  Q;
   logic [8:0]  R;
   logic        outValid;
   logic        outReady;

   int checkCount = 0;
   int errorCount = 0;

   // Directed vectors: operand, root, remainder, latency (full / early exit)
   int vecX    [8] = '{144, 200, 65535, 0, 1, 3, 65025, 16384};
   int vecQ    [8] = '{12,  14,  255,   0, 1, 1, 255,   128};
   int vecR    [8] = '{0,   4,   510,   0, 0, 2, 0,     0};
   int vecLatD [8] = '{8,   8,   8,     8, 8, 8, 8,     8};
   int vecLatE [8] = '{4,   4,   8,     1, 1, 1, 8,     8};

   always #5 clk = ~clk;

   sqrt_uns_seq #(
      .width(Width)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .X          (X),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .Q          (Q),
      .R          (R),
      .out_valid_o(outValid),
      .out_ready_i(outReady)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One full transaction with the consumer always ready; returns result
   // and the number of cycles from accept edge to out_valid
   task automatic applyStimulus(input logic [15:0] x, output logic [7:0] q,
                                output logic [8:0] r, output int lat);
      int waitCycles;
      waitCycles = 0;
      outReady   = 1'b1;
      while (!inReady && waitCycles < 50) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput("inReadyWait", inReady, 1);
      X       = x;
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      lat = 0;
      while (!outValid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("outValidWait", outValid, 1);
      q = Q;
      r = R;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0]  q;
      logic [8:0]  r;
      logic [15:0] x;
      int          lat;
      int          n;
      logic        ghost;
      int          acc;
      int          res;
      int          accE [2];
      logic [7:0]  gotQ [2];
      logic [8:0]  gotR [2];

      rst      = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b1;
      X        = '0;

      // Reset state
      @(posedge clk); #1;
      checkOutput("rstInReady", inReady, 0);
      checkOutput("rstOutValid", outValid, 0);
      checkOutput("rstQ", Q, 0);
      checkOutput("rstR", R, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("postRstInReady", inReady, 1);
      checkOutput("postRstOutValid", outValid, 0);

      // Directed vectors with latency
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'(vecX[i]), q, r, lat);
         checkOutput($sformatf("vecQ[%0d]", vecX[i]), q, vecQ[i]);
         checkOutput($sformatf("vecR[%0d]", vecX[i]), r, vecR[i]);
         checkOutput($sformatf("vecLat[%0d]", vecX[i]), lat,
                     EarlyExit ? vecLatE[i] : vecLatD[i]);
         checkOutput("idleAfterHandshake", inReady, 1);
      end

      // Backpressure: result held for 5 cycles, second request ignored
      outReady = 1'b0;
      X        = 16'd200;
      inValid  = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      n = 0;
      while (!outValid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("bpValid", outValid, 1);
      for (int c = 0; c < 5; c++) begin
         checkOutput("bpQ", Q, 14);
         checkOutput("bpR", R, 4);
         checkOutput("bpInReady", inReady, 0);
         checkOutput("bpHold", outValid, 1);
         inValid = (c == 2);
         X       = 16'd9;
         @(posedge clk); #1;
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("bpReleaseValid", outValid, 0);
      checkOutput("bpReleaseReady", inReady, 1);
      ghost = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (outValid) ghost = 1'b1;
         @(posedge clk); #1;
      end
      checkOutput("bpNoSecondOp", ghost, 0);

      // Reset in the middle of CALC discards the operation
      X       = 16'hFFFF;
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midRstOutValid", outValid, 0);
      checkOutput("midRstQ", Q, 0);
      checkOutput("midRstR", R, 0);
      checkOutput("midRstInReady", inReady, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("midRstIdle", inReady, 1);
      ghost = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (outValid) ghost = 1'b1;
         @(posedge clk); #1;
      end
      checkOutput("midRstNoResult", ghost, 0);
      applyStimulus(16'd49, q, r, lat);
      checkOutput("after49Q", q, 7);
      checkOutput("after49R", r, 0);
      checkOutput("after49Lat", lat, EarlyExit ? 3 : 8);

      // Back-to-back with in_valid held high: 81 then 80
      X       = 16'd81;
      inValid = 1'b1;
      acc     = 0;
      res     = 0;
      accE    = '{0, 0};
      gotQ    = '{8'd0, 8'd0};
      gotR    = '{9'd0, 9'd0};
      for (int c = 0; c < 60 && res < 2; c++) begin
         if (inReady && inValid && acc < 2) begin
            accE[acc] = c;
            acc++;
         end
         if (outValid && res < 2) begin
            gotQ[res] = Q;
            gotR[res] = R;
            res++;
         end
         @(posedge clk); #1;
         if (acc == 1) X = 16'd80;
         if (acc == 2) inValid = 1'b0;
      end
      inValid = 1'b0;
      checkOutput("b2bAccepts", acc, 2);
      checkOutput("b2bResults", res, 2);
      checkOutput("b2bQ0", gotQ[0], 9);
      checkOutput("b2bR0", gotR[0], 0);
      checkOutput("b2bQ1", gotQ[1], 8);
      checkOutput("b2bR1", gotR[1], 16);
      checkOutput("b2bInterval", accE[1] - accE[0], EarlyExit ? 6 : 10);
      @(posedge clk); #1;

      // Perfect squares: every root must come back exactly with zero remainder
      for (int k = 0; k < 256; k++) begin
         applyStimulus(16'(k * k), q, r, lat);
         checkOutput($sformatf("sqQ[%0d]", k), q, k);
         checkOutput($sformatf("sqR[%0d]", k), r, 0);
      end

      // Random operands: Q*Q + R must equal X and R must not exceed 2Q
      for (int k = 0; k < 300; k++) begin
         x = 16'($urandom);
         applyStimulus(x, q, r, lat);
         checkOutput($sformatf("rndSum[%0d]", x), int'(q) * int'(q) + int'(r), x);
         checkOutput($sformatf("rndRemBound[%0d]", x), (int'(r) <= 2 * int'(q)), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
